// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Function : 5-stage pipeline latch enables/flushes, load-use stall,
//             taken-branch flush and multdiv start/wait/done sequencing.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      fd_insn,
    input  logic [31:0]      dx_insn,
    input  logic             br_taken,
    input  logic             md_rdy,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_sel,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] c_OP_R    = 5'b00000;
    localparam logic [4:0] c_OP_LW   = 5'b01000;
    localparam logic [4:0] c_OP_SW   = 5'b00111;
    localparam logic [4:0] c_ALU_MUL = 5'b00110;
    localparam logic [4:0] c_ALU_DIV = 5'b00111;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int c_WCNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

    logic [1:0]          r_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_md_err;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [4:0] w_dx_op, w_dx_rd, w_dx_aluop;
    logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
    logic       w_dx_md, w_load_use;
    logic       w_unused_bits;

    assign w_dx_op    = dx_insn[31:27];
    assign w_dx_rd    = dx_insn[26:22];
    assign w_dx_aluop = dx_insn[6:2];
    assign w_fd_op    = fd_insn[31:27];
    assign w_fd_rd    = fd_insn[26:22];
    assign w_fd_rs    = fd_insn[21:17];
    assign w_fd_rt    = fd_insn[16:12];

    assign w_unused_bits = ^{dx_insn[21:7], dx_insn[1:0], fd_insn[11:0]};

    assign w_dx_md = (w_dx_op == c_OP_R) &&
                     ((w_dx_aluop == c_ALU_MUL) || (w_dx_aluop == c_ALU_DIV));

    // Only sources actually read by the F/D instruction's format count.
    assign w_load_use = (w_dx_op == c_OP_LW) && (w_dx_rd != 5'd0) &&
                        ((w_fd_rs == w_dx_rd) ||
                         ((w_fd_op == c_OP_R)  && (w_fd_rt == w_dx_rd)) ||
                         ((w_fd_op == c_OP_SW) && (w_fd_rd == w_dx_rd)));

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        md_start = 1'b0;
        md_sel   = 1'b0;
        if (!clr) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            xm_en = 1'b0;
            mw_en = 1'b0;
        end else begin
            case (r_state)
                c_START, c_WAIT: begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_en    = 1'b0;
                    xm_flush = 1'b1;
                    md_start = (r_state == c_START);
                end
                c_DONE: md_sel = 1'b1;
                default: begin
                    // A multdiv about to start outranks branch and hazard.
                    if (!w_dx_md) begin
                        if (br_taken) begin
                            fd_flush = 1'b1;
                            dx_flush = 1'b1;
                        end else if (w_load_use) begin
                            pc_en    = 1'b0;
                            fd_en    = 1'b0;
                            dx_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= c_IDLE;
            r_wait_cnt  <= '0;
            r_md_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (!pc_en) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            case (r_state)
                c_IDLE:  if (w_dx_md) r_state <= c_START;
                c_START: begin
                    r_state    <= c_WAIT;
                    r_wait_cnt <= '0;
                end
                c_WAIT: begin
                    if (md_rdy) begin
                        r_state <= c_DONE;
                    end else if (r_wait_cnt == c_WCNT_W'(MD_TIMEOUT - 1)) begin
                        r_state  <= c_DONE;
                        r_md_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WCNT_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign md_err    = r_md_err;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Function : directed + randomized bench for pipe_hazard_ctrl against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MD_TIMEOUT = 64;
    localparam int CNT_W      = 32;

    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd5;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic [31:0]      fd_insn = '0;
    logic [31:0]      dx_insn = '0;
    logic             br_taken = 1'b0;
    logic             md_rdy = 1'b0;
    logic             pc_en, fd_en, dx_en, xm_en, mw_en;
    logic             fd_flush, dx_flush, xm_flush, md_start, md_sel, md_err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .fd_insn(fd_insn), .dx_insn(dx_insn),
        .br_taken(br_taken), .md_rdy(md_rdy),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_start(md_start), .md_sel(md_sel), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: age of the outstanding multdiv op (-1 = none,
    // 0 = launch cycle, k = k-th cycle spent waiting for the result).
    int               md_age  = -1;
    bit               md_done = 1'b0;
    bit               exp_err = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, aluop);
        return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    function automatic bit is_md(input logic [31:0] x);
        return (x[31:27] == OP_R) && (x[6:2] == 5'd6 || x[6:2] == 5'd7);
    endfunction

    function automatic bit reads_reg(input logic [31:0] f, input logic [4:0] r);
        bit hit;
        hit = (f[21:17] == r);
        if (f[31:27] == OP_R  && f[16:12] == r) hit = 1'b1;
        if (f[31:27] == OP_SW && f[26:22] == r) hit = 1'b1;
        return hit;
    endfunction

    // {pc,fd,dx,xm,mw,fd_flush,dx_flush,xm_flush,md_start,md_sel,md_err}
    function automatic logic [10:0] predict();
        logic [4:0] en;
        logic [2:0] fl;
        logic st, sel;
        if (!clr) return 11'd0;
        en = 5'b11111; fl = 3'b000; st = 1'b0; sel = 1'b0;
        if (md_age >= 0) begin
            en = 5'b00011; fl = 3'b001; st = (md_age == 0);
        end else if (md_done) begin
            sel = 1'b1;
        end else if (!is_md(dx_insn)) begin
            if (br_taken) fl = 3'b110;
            else if (dx_insn[31:27] == OP_LW && dx_insn[26:22] != 5'd0 &&
                     reads_reg(fd_insn, dx_insn[26:22])) begin
                en = 5'b00111; fl = 3'b010;
            end
        end
        return {en, fl, st, sel, exp_err};
    endfunction

    task automatic check(input string tag);
        logic [10:0] exp_v, obs_v;
        exp_v = predict();
        obs_v = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
                 md_start, md_sel, md_err};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_v, exp_v);
        end
        vectors++;
        assert (stall_cnt === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_cnt);
        end
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx,
                        input logic br, input logic rdy, input string tag);
        logic [10:0] p;
        fd_insn = fd; dx_insn = dx; br_taken = br; md_rdy = rdy;
        #4;
        check(tag);
        p = predict();
        @(posedge clk);
        if (!p[10]) exp_cnt++;
        if (md_done) begin
            md_done = 1'b0;
        end else if (md_age < 0) begin
            if (is_md(dx)) md_age = 0;
        end else if (md_age == 0) begin
            md_age = 1;
        end else if (rdy || md_age == MD_TIMEOUT) begin
            if (!rdy) exp_err = 1'b1;
            md_age = -1; md_done = 1'b1;
        end else begin
            md_age++;
        end
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        clr = 1'b0;
        md_age = -1; md_done = 1'b0; exp_err = 1'b0; exp_cnt = '0;
        #4;
        check(tag);
        @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0] op;
        case ($urandom_range(0, 3))
            0: op = OP_R;
            1: op = OP_LW;
            2: op = OP_SW;
            default: op = OP_ADDI;
        endcase
        return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endfunction

    logic [31:0] nop, mul, dv;

    initial begin
        nop = '0;
        mul = mk(OP_R, 5'd3, 5'd1, 5'd2, 5'd6);
        dv  = mk(OP_R, 5'd4, 5'd1, 5'd2, 5'd7);

        @(posedge clk); #1;
        check("reset");
        @(posedge clk); #1;
        clr = 1'b1;

        // load-use: lw r5 followed by add r6,r5,r2, then the bubble
        step(mk(OP_R, 5'd6, 5'd5, 5'd2, 5'd0), mk(OP_LW, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, "lu_stall");
        step(mk(OP_R, 5'd6, 5'd5, 5'd2, 5'd0), nop, 0, 0, "lu_clear");
        step(mk(OP_R, 5'd1, 5'd2, 5'd7, 5'd0), mk(OP_LW, 5'd7, 5'd1, 5'd0, 5'd0), 0, 0, "lu_rt");
        step(mk(OP_SW, 5'd7, 5'd1, 5'd0, 5'd0), mk(OP_LW, 5'd7, 5'd2, 5'd0, 5'd0), 0, 0, "lu_sw");
        step(mk(OP_SW, 5'd2, 5'd1, 5'd7, 5'd0), mk(OP_LW, 5'd7, 5'd2, 5'd0, 5'd0), 0, 0, "sw_rt_ok");
        step(mk(OP_R, 5'd1, 5'd0, 5'd0, 5'd0), mk(OP_LW, 5'd0, 5'd1, 5'd0, 5'd0), 0, 0, "lw_r0");
        step(mk(OP_ADDI, 5'd6, 5'd1, 5'd5, 5'd0), mk(OP_LW, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, "addi_rt");

        // MUL, result 10 cycles after md_start; md_rdy during START ignored
        step(nop, mul, 0, 0, "mul_idle");
        step(nop, mul, 0, 1, "mul_start");
        for (int k = 1; k < 10; k++) step(nop, mul, 0, 0, "mul_wait");
        step(nop, mul, 0, 1, "mul_rdy");
        step(nop, mul, 0, 0, "mul_done");
        step(nop, nop, 0, 0, "mul_after");

        // DIV timeout
        step(nop, dv, 0, 0, "div_idle");
        step(nop, dv, 0, 0, "div_start");
        for (int k = 1; k <= MD_TIMEOUT; k++) step(nop, dv, 0, 0, "div_wait");
        step(nop, dv, 0, 0, "div_done");
        for (int k = 0; k < 4; k++) step(rand_insn(), nop, 0, 0, "err_sticky");

        // taken branch beats load-use hazard
        step(mk(OP_R, 5'd6, 5'd5, 5'd2, 5'd0), mk(OP_LW, 5'd5, 5'd1, 5'd0, 5'd0), 1, 0, "br_flush");

        // reset pulse in the middle of WAIT, then a late md_rdy
        step(nop, mul, 0, 0, "rst_idle");
        step(nop, mul, 0, 0, "rst_start");
        for (int k = 0; k < 3; k++) step(nop, mul, 0, 0, "rst_wait");
        reset_pulse("rst_mid");
        step(nop, nop, 0, 1, "late_rdy");
        step(nop, nop, 0, 1, "late_rdy2");

        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_pulse("rand_rst");
            step(rand_insn(), ($urandom_range(0, 5) == 0) ? mul : rand_insn(),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
